// File: rtl/i3c_ram_1p_arb_pkg.sv
// Shared types for the I3C single-port RAM arbiter.
//   state_e : sequencer states (array initialisation, normal operation)
//   port_e  : requester identity carried with each in-flight read
//   tag_t   : one entry of the read-response routing shift register
package i3c_ram_1p_arb_pkg;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  typedef enum logic {
    PortA = 1'b0,
    PortB = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

  localparam int ErrCntW = 16;

endpackage

// File: rtl/i3c_ram_1p_arb.sv
// Two-requester arbiter and sequencer for a parity-protected single-port RAM.
// After reset the whole array is zero-filled (optional) so every word holds
// valid parity; afterwards requesters A and B share the RAM port round-robin.
// Read responses are steered back to the issuing requester and responses that
// carry a parity error are counted in a saturating counter.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   {a,b}_req_i / _gnt_o      request / grant handshake (accept = req & gnt)
//   {a,b}_write_i, _addr_i,
//   _wdata_i, _wmask_i        request fields, held stable until granted
//   {a,b}_rvalid_o, _rerror_o read response strobe and error flags
//   rdata_o                   shared read data, qualified by a/b_rvalid_o
//   ram_*_o / ram_*_i         RAM wrapper request and response ports
//   init_done_o               high once the array is initialised
//   err_cnt_o, err_clr_i      parity-error count and its clear
module i3c_ram_1p_arb
  import i3c_ram_1p_arb_pkg::*;
#(
  parameter int Depth       = 512,
  parameter int Width       = 32,
  parameter int ReadLatency = 1,
  parameter bit InitOnReset = 1'b1,
  parameter int Aw          = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic               a_req_i,
  output logic               a_gnt_o,
  input  logic               a_write_i,
  input  logic [Aw-1:0]      a_addr_i,
  input  logic [Width-1:0]   a_wdata_i,
  input  logic [Width-1:0]   a_wmask_i,
  output logic               a_rvalid_o,
  output logic [1:0]         a_rerror_o,

  input  logic               b_req_i,
  output logic               b_gnt_o,
  input  logic               b_write_i,
  input  logic [Aw-1:0]      b_addr_i,
  input  logic [Width-1:0]   b_wdata_i,
  input  logic [Width-1:0]   b_wmask_i,
  output logic               b_rvalid_o,
  output logic [1:0]         b_rerror_o,

  output logic [Width-1:0]   rdata_o,

  output logic               ram_req_o,
  output logic               ram_write_o,
  output logic [Aw-1:0]      ram_addr_o,
  output logic [Width-1:0]   ram_wdata_o,
  output logic [Width-1:0]   ram_wmask_o,
  input  logic [Width-1:0]   ram_rdata_i,
  input  logic               ram_rvalid_i,
  input  logic [1:0]         ram_rerror_i,

  output logic               init_done_o,
  output logic [ErrCntW-1:0] err_cnt_o,
  input  logic               err_clr_i
);

  localparam logic [Aw-1:0] InitLast = Aw'(Depth - 1);

  function automatic logic [ErrCntW-1:0] sat_inc(input logic [ErrCntW-1:0] v);
    return (&v) ? v : v + ErrCntW'(1);
  endfunction

  state_e               state_q, state_d;
  logic [Aw-1:0]        init_cnt_q;
  port_e                last_q;
  tag_t                 tag_p [ReadLatency];
  tag_t                 tail;
  logic [ErrCntW-1:0]   err_cnt_q, err_cnt_d;
  logic                 a_gnt, b_gnt, acc_read, err_inc;

  // Request side: init sequencer or round-robin grant, RAM port mux.
  // Everything is held idle while rst_i is high so the port reads as
  // quiescent during reset regardless of the state register.
  always_comb begin
    state_d     = state_q;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    if (!rst_i) begin
      case (state_q)
        StInit: begin
          ram_req_o   = 1'b1;
          ram_write_o = 1'b1;
          ram_addr_o  = init_cnt_q;
          ram_wmask_o = '1;
          if (init_cnt_q == InitLast) state_d = StRun;
        end
        StRun: begin
          // On conflict the requester not granted most recently wins.
          a_gnt = a_req_i & (~b_req_i | (last_q == PortB));
          b_gnt = b_req_i & ~a_gnt;
          if (a_gnt) begin
            ram_req_o   = 1'b1;
            ram_write_o = a_write_i;
            ram_addr_o  = a_addr_i;
            ram_wdata_o = a_wdata_i;
            ram_wmask_o = a_wmask_i;
          end else if (b_gnt) begin
            ram_req_o   = 1'b1;
            ram_write_o = b_write_i;
            ram_addr_o  = b_addr_i;
            ram_wdata_o = b_wdata_i;
            ram_wmask_o = b_wmask_i;
          end
        end
      endcase
    end
  end

  assign a_gnt_o     = a_gnt;
  assign b_gnt_o     = b_gnt;
  assign init_done_o = (state_q == StRun) & ~rst_i;
  assign acc_read    = (a_gnt & ~a_write_i) | (b_gnt & ~b_write_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= InitOnReset ? StInit : StRun;
      init_cnt_q <= '0;
      last_q     <= PortB;
      err_cnt_q  <= '0;
      for (int i = 0; i < ReadLatency; i++) tag_p[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StInit) init_cnt_q <= init_cnt_q + Aw'(1);
      if (a_gnt)      last_q <= PortA;
      else if (b_gnt) last_q <= PortB;
      err_cnt_q <= err_cnt_d;
      // Tag stage 0: one entry per cycle, writes and idle cycles insert valid=0.
      tag_p[0] <= '{valid: acc_read, port: (b_gnt ? PortB : PortA)};
      for (int i = 1; i < ReadLatency; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  // Response side: the tail tag lines up with the RAM response of the same read.
  assign tail       = tag_p[ReadLatency-1];
  assign a_rvalid_o = ram_rvalid_i & tail.valid & (tail.port == PortA);
  assign b_rvalid_o = ram_rvalid_i & tail.valid & (tail.port == PortB);
  assign a_rerror_o = a_rvalid_o ? ram_rerror_i : 2'b00;
  assign b_rerror_o = b_rvalid_o ? ram_rerror_i : 2'b00;
  assign rdata_o    = ram_rdata_i;

  // A clear that coincides with an error keeps that error, so the count is 1.
  assign err_inc   = (a_rvalid_o | b_rvalid_o) & (|ram_rerror_i);
  assign err_cnt_d = err_clr_i ? ErrCntW'(err_inc)
                   : (err_inc ? sat_inc(err_cnt_q) : err_cnt_q);
  assign err_cnt_o = err_cnt_q;

  // A RAM response with no read in flight means the RAM and this block disagree.
  rvalid_has_tag: assert property (@(posedge clk_i) disable iff (rst_i)
                                   ram_rvalid_i |-> tail.valid);

endmodule

// File: tb/tb_i3c_ram_1p_arb.sv
module tb_i3c_ram_1p_arb;
  localparam int Depth = 16;
  localparam int Width = 32;
  localparam int RL    = 2;
  localparam int Aw    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_req, a_write, a_gnt, a_rvalid;
  logic [Aw-1:0]    a_addr;
  logic [Width-1:0] a_wdata, a_wmask;
  logic [1:0]       a_rerror;
  logic             b_req, b_write, b_gnt, b_rvalid;
  logic [Aw-1:0]    b_addr;
  logic [Width-1:0] b_wdata, b_wmask;
  logic [1:0]       b_rerror;
  logic [Width-1:0] rdata;
  logic             ram_req, ram_write, ram_rvalid;
  logic [Aw-1:0]    ram_addr;
  logic [Width-1:0] ram_wdata, ram_wmask, ram_rdata;
  logic [1:0]       ram_rerror;
  logic             init_done, err_clr;
  logic [15:0]      err_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i3c_ram_1p_arb #(.Depth(Depth), .Width(Width), .ReadLatency(RL), .InitOnReset(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_write_i(a_write), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_wmask_i(a_wmask), .a_rvalid_o(a_rvalid), .a_rerror_o(a_rerror),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_write_i(b_write), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_wmask_i(b_wmask), .b_rvalid_o(b_rvalid), .b_rerror_o(b_rerror),
    .rdata_o(rdata),
    .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask),
    .ram_rdata_i(ram_rdata), .ram_rvalid_i(ram_rvalid), .ram_rerror_i(ram_rerror),
    .init_done_o(init_done), .err_cnt_o(err_cnt), .err_clr_i(err_clr)
  );

  // Behavioural parity RAM: one input pipeline stage, so read latency is 2 and a
  // write commits one edge after acceptance. Parity is one even bit per byte.
  logic [Width-1:0] mem [Depth];
  logic [3:0]       par [Depth];
  logic             m_v, m_w;
  logic [Aw-1:0]    m_a;
  logic [Width-1:0] m_d, m_m;
  logic             corrupt_en;
  logic [Aw-1:0]    corrupt_addr;
  logic [3:0]       flip;

  function automatic logic [3:0] par_of(input logic [31:0] d);
    logic [3:0] p;
    for (int b = 0; b < 4; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  assign flip = (corrupt_en && (m_a == corrupt_addr)) ? 4'b0001 : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_v        <= 1'b0;
      ram_rvalid <= 1'b0;
    end else begin
      m_v        <= ram_req;
      m_w        <= ram_write;
      m_a        <= ram_addr;
      m_d        <= ram_wdata;
      m_m        <= ram_wmask;
      ram_rvalid <= m_v & ~m_w;
      if (m_v && m_w) begin
        for (int b = 0; b < 4; b++) begin
          if (m_m[8*b]) begin
            mem[m_a][8*b +: 8] <= m_d[8*b +: 8];
            par[m_a][b]        <= ^m_d[8*b +: 8];
          end
        end
      end
      if (m_v && !m_w) begin
        ram_rdata  <= mem[m_a];
        ram_rerror <= ((par_of(mem[m_a]) ^ par[m_a] ^ flip) != 4'b0000) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0;
    a_req = 1'b1; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_wmask = '1;
    b_req = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_wmask = '1;

    // Reset state, with A already requesting.
    repeat (3) @(negedge clk);
    #1;
    chk("rst a_gnt", a_gnt, 0);
    chk("rst b_gnt", b_gnt, 0);
    chk("rst ram_req", ram_req, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst init_done", init_done, 0);
    chk("rst err_cnt", err_cnt, 0);
    chk("rst a_rvalid", a_rvalid, 0);

    // Init sweep: 16 zero writes, A held off throughout.
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < Depth; k++) begin
      #1;
      chk("init req", ram_req, 1);
      chk("init write", ram_write, 1);
      chk("init addr", ram_addr, k);
      chk("init wdata", ram_wdata, 0);
      chk("init wmask", ram_wmask, 32'hFFFF_FFFF);
      chk("init a_gnt", a_gnt, 0);
      chk("init done low", init_done, 0);
      @(negedge clk);
    end
    #1;
    chk("init_done at 16", init_done, 1);
    chk("first grant A", a_gnt, 1);
    chk("first grant read", ram_write, 0);
    @(negedge clk);
    a_req = 1'b0;
    #1;
    chk("a_rvalid early", a_rvalid, 0);
    @(negedge clk);
    #1;
    chk("init read a_rvalid", a_rvalid, 1);
    chk("init read data", rdata, 0);
    chk("init read rerror", a_rerror, 0);

    // Seed addresses 3 and 5, A then B, leaving B as last granted.
    @(negedge clk);
    a_req = 1'b1; a_write = 1'b1; a_addr = 4'd3; a_wdata = 32'h3333_3333;
    #1;
    chk("seed a_gnt", a_gnt, 1);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b1; b_write = 1'b1; b_addr = 4'd5; b_wdata = 32'h5555_5555;
    #1;
    chk("seed b_gnt", b_gnt, 1);
    @(negedge clk);
    b_req = 1'b0;

    // Conflict: both read every cycle for 4 cycles -> A,B,A,B.
    a_write = 1'b0; b_write = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        a_req = 1'b0; b_req = 1'b0;
      end
      #1;
      if (k < 4) begin
        chk("rr a_gnt", a_gnt, (k % 2) == 0);
        chk("rr b_gnt", b_gnt, (k % 2) == 1);
        chk("rr ram_addr", ram_addr, ((k % 2) == 0) ? 3 : 5);
      end
      if (k >= 2) begin
        chk("rr a_rvalid", a_rvalid, (k % 2) == 0);
        chk("rr b_rvalid", b_rvalid, (k % 2) == 1);
        chk("rr rdata", rdata, ((k % 2) == 0) ? 32'h3333_3333 : 32'h5555_5555);
      end
      @(negedge clk);
    end

    // Write then read-after-write to address 7.
    a_req = 1'b1; a_write = 1'b1; a_addr = 4'd7; a_wdata = 32'hDEAD_BEEF;
    #1;
    chk("raw a_gnt", a_gnt, 1);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b1; b_write = 1'b0; b_addr = 4'd7;
    #1;
    chk("raw b_gnt", b_gnt, 1);
    @(negedge clk);
    b_req = 1'b0;
    @(negedge clk);
    #1;
    chk("raw b_rvalid", b_rvalid, 1);
    chk("raw a_rvalid", a_rvalid, 0);
    chk("raw rdata", rdata, 32'hDEAD_BEEF);
    chk("raw b_rerror", b_rerror, 0);

    // Parity error at address 2.
    corrupt_en = 1'b1; corrupt_addr = 4'd2;
    @(negedge clk);
    a_req = 1'b1; a_write = 1'b0; a_addr = 4'd2;
    #1;
    chk("par a_gnt", a_gnt, 1);
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    #1;
    chk("par a_rvalid", a_rvalid, 1);
    chk("par a_rerror", a_rerror, 2'b10);
    chk("par b_rerror", b_rerror, 2'b00);
    @(negedge clk);
    #1;
    chk("par err_cnt 1", err_cnt, 1);
    // Clear together with a second error.
    a_req = 1'b1;
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    #1;
    chk("clr+err a_rerror", a_rerror, 2'b10);
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("clr+err err_cnt", err_cnt, 1);
    // Clear alone.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("clr err_cnt", err_cnt, 0);

    // Saturation: preload 0xFFFE, then three back-to-back errors.
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt_q;
    #1;
    chk("sat preload", err_cnt, 16'hFFFE);
    @(negedge clk);
    a_req = 1'b1; a_write = 1'b0; a_addr = 4'd2;
    repeat (3) @(negedge clk);
    a_req = 1'b0;
    #1;
    chk("sat mid a_rvalid", a_rvalid, 1);
    chk("sat first inc", err_cnt, 16'hFFFF);
    repeat (2) @(negedge clk);
    #1;
    chk("sat hold", err_cnt, 16'hFFFF);

    // Reset while a read is in flight.
    corrupt_en = 1'b0;
    @(negedge clk);
    a_req = 1'b1; a_write = 1'b0; a_addr = 4'd3;
    #1;
    chk("mid a_gnt", a_gnt, 1);
    @(negedge clk);
    a_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid a_rvalid", a_rvalid, 0);
    chk("mid init req", ram_req, 1);
    chk("mid init write", ram_write, 1);
    chk("mid init addr", ram_addr, 0);
    chk("mid init_done", init_done, 0);
    chk("mid err_cnt", err_cnt, 0);
    @(negedge clk);
    #1;
    chk("mid a_rvalid late", a_rvalid, 0);
    chk("mid init addr 1", ram_addr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/i3c_ram_1p_arb.md
# i3c_ram_1p_arb

Two-requester arbiter and sequencer for one parity-protected single-port SRAM wrapper (`prim_ram_1p_adv`, EnableParity=1). It initialises the whole array after reset so every word carries valid parity. It then shares the single RAM port between requesters A and B with round-robin arbitration. Read responses are routed back to the issuing requester, and parity errors are counted. It sits between the I3C FIFO/queue logic and the RAM macro wrapper.

## Interface
Parameters:
- Depth, 512: RAM words; Aw = vbits(Depth).
- Width, 32: data width; must be a multiple of 8.
- ReadLatency, 1: RAM read latency in cycles, legal 1..3. Equals 1 + input pipeline + output pipeline of the attached RAM.
- InitOnReset, 1: 1 = zero-fill the array after reset; 0 = go straight to RUN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high. Attached RAM's active-low reset input is driven with its inverse.
- a_req_i  in  1  request A; held until granted.
- a_gnt_o  out  1  grant A, combinational from a_req_i and state.
- a_write_i  in  1  1 = write, 0 = read.
- a_addr_i  in  Aw  word address.
- a_wdata_i  in  Width  write data.
- a_wmask_i  in  Width  write mask, byte granular.
- a_rvalid_o  out  1  read response for A.
- a_rerror_o  out  2  response error; bit1 uncorrectable, bit0 correctable.
- b_*  same set as a_*, for requester B.
- rdata_o  out  Width  read data, shared; qualified by a_rvalid_o or b_rvalid_o.
- ram_req_o, ram_write_o, ram_addr_o[Aw], ram_wdata_o[Width], ram_wmask_o[Width]  out  RAM request port.
- ram_rdata_i[Width], ram_rvalid_i, ram_rerror_i[2]  in  RAM response port.
- init_done_o  out  1  high in RUN.
- err_cnt_o  out  16  saturating parity-error count.
- err_clr_i  in  1  clears err_cnt_o.

## Operation
- **FSM states: INIT, RUN.**
  - Reset enters INIT if InitOnReset=1, otherwise RUN.
  - INIT: init address counter runs 0..Depth-1, one write per cycle. Each write has wdata 0 and wmask all ones. Both grants are held low.
  - INIT -> RUN after the write to Depth-1 is issued.
  - RUN persists until reset.
- **Arbitration (RUN):**
  - A request is accepted in a cycle where req & gnt; the RAM request is driven the same cycle.
  - Only one requester present: it is granted.
  - Both present: grant goes to the requester not granted most recently.
  - The last-granted pointer updates on every grant; its reset value is B, so A wins the first conflict.
  - The losing requester keeps req high and its request fields stable.
- **Response routing:**
  - A ReadLatency-deep shift register of {valid, port} records each accepted read. Writes insert valid=0.
  - When ram_rvalid_i=1, the tail entry selects a_rvalid_o or b_rvalid_o.
  - Tail valid=0 while ram_rvalid_i=1 is a protocol error: assertion fires and no rvalid is raised.
  - x_rerror_o = ram_rerror_i when x_rvalid_o=1, else 0.
  - rdata_o = ram_rdata_i, unconditionally.
- **Error counter:**
  - Increments by 1 on any routed response with ram_rerror_i != 0.
  - Saturates at 0xFFFF.
  - err_clr_i alone sets it to 0. err_clr_i coinciding with an increment gives 1.

## Timing
- Reset values:
  - gnt, rvalid and rerror outputs, ram_req_o and init_done_o are 0.
  - err_cnt_o is 0; the shift register is cleared.
  - ram_addr_o, ram_wdata_o and ram_wmask_o are 0 while idle.
- Init takes exactly Depth cycles. init_done_o rises on the cycle after the last init write; the first grant is possible that same cycle.
- A read accepted in cycle t produces x_rvalid_o in cycle t+ReadLatency.
- Back-to-back accepted reads yield back-to-back responses; full throughput is one access per cycle.
- A write is committed at the RAM clock edge ReadLatency-1 cycles after acceptance. A read to the same address accepted the next cycle returns the new data.
- Reset mid-operation:
  - In-flight tags are dropped; no rvalid is raised for them.
  - The FSM restarts INIT from address 0.
  - err_cnt_o is cleared.

## Structure
- Package i3c_ram_1p_arb_pkg contains:
  - the state enum {StInit, StRun};
  - the port-id typedef (PortA=0, PortB=1);
  - the tag struct {valid, port};
  - the constant ErrCntW=16.
- One module; no sub-module. The round-robin is too small to split out.
- The bench instantiates the block with prim_ram_1p_adv for integration tests.

## Test plan
- **Init sweep:** Depth=16, InitOnReset=1, reset released -> 16 consecutive writes to addresses 0..15 with data 0, init_done_o high at cycle 16, and no grants before that.
- **Conflict round-robin:** A and B both request reads of addresses 3 and 5 every cycle for 4 cycles -> grants A,B,A,B. Responses route A,B,A,B at ReadLatency=2 offset.
- **Write/read ordering:** A writes 0xDEADBEEF to address 7; B reads address 7 the next cycle -> b_rvalid_o with rdata_o=0xDEADBEEF and b_rerror_o=0.
- **Parity error:** force a flipped parity bit at address 2 and read it via A -> a_rerror_o=2'b10 and err_cnt_o=1. Assert err_clr_i together with a second error -> err_cnt_o=1.
- **Saturation:** preload the counter to 0xFFFE, then inject 3 errors -> err_cnt_o holds at 0xFFFF.
- **Reset mid-flight:** A read accepted, then rst_i asserted for 1 cycle before the response -> no a_rvalid_o, INIT restarts at address 0, err_cnt_o=0.
